// File: rtl/conv55_pkg.sv
// Shared constants and helpers for the 5x5 sliding-window generator.
package conv55_pkg;
  localparam int DATA_W = 8;
  localparam int K      = 5;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int WIN_W  = K*K*DATA_W;
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  function automatic int win_idx(input int r, input int c);
    return r*K + c;
  endfunction
endpackage

// File: rtl/conv55_line_buf.sv
// One image row of pixel storage; read-before-write so the chain shifts rows on each accept.
module conv55_line_buf
  import conv55_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [COL_W-1:0]  addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [IMG_W];

  // Contents are never reset; row gating upstream hides stale entries.
  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wr_data_i;
  end
endmodule

// File: rtl/conv55_window_gen.sv
// Streaming 5x5 window generator: K-1 chained line buffers feed a KxK shift window.
module conv55_window_gen
  import conv55_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIN_W-1:0]  win_flat,
  output logic              frame_done
);
  localparam logic [COL_W-1:0] X_LAST = COL_W'(IMG_W-1);
  localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(IMG_H-1);
  localparam logic [COL_W-1:0] X_MIN  = COL_W'(K-1);
  localparam logic [ROW_W-1:0] Y_MIN  = ROW_W'(K-1);

  logic                                 accept;
  logic [COL_W-1:0]                     col_q, col_d;
  logic [ROW_W-1:0]                     row_q, row_d;
  logic                                 vld_q, vld_d;
  logic                                 fd_q, fd_d;
  logic [K-1:0][K-1:0][DATA_W-1:0]      win_q, win_d;
  logic [K-2:0][DATA_W-1:0]             lb_rd, lb_wr;
  logic [K-1:0][DATA_W-1:0]             col_new;

  assign in_ready   = !vld_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_valid  = vld_q;
  assign frame_done = fd_q;

  // lb 0 holds row y-1; each later buffer is one row older.
  for (genvar i = 0; i < K-1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = in_pixel;
    end else begin : g_chain
      assign lb_wr[i] = lb_rd[i-1];
    end
    conv55_line_buf u_lb (
      .clk       (clk),
      .we_i      (accept),
      .addr_i    (col_q),
      .wr_data_i (lb_wr[i]),
      .rd_data_o (lb_rd[i])
    );
    assign col_new[i] = lb_rd[K-2-i];
  end
  assign col_new[K-1] = in_pixel;

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign win_flat[win_idx(r, c)*DATA_W +: DATA_W] = win_q[r][c];
    end
  end

  always_comb begin
    win_d = win_q;
    col_d = col_q;
    row_d = row_q;
    vld_d = vld_q;
    fd_d  = 1'b0;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = col_new[r];
      end
      vld_d = (row_q >= Y_MIN) && (col_q >= X_MIN);
      if (col_q == X_LAST) begin
        col_d = '0;
        if (row_q == Y_LAST) begin
          row_d = '0;
          fd_d  = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      col_q <= '0;
      row_q <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      win_q <= win_d;
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= vld_d;
      fd_q  <= fd_d;
    end
  end
endmodule

// File: tb/tb_conv55_window_gen.sv
// Directed bench for conv55_window_gen using ramp frames with hand-derived windows.
module tb_conv55_window_gen;
  import conv55_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIN_W-1:0]  win_flat;
  logic              frame_done;

  int tests = 0;
  int fails = 0;

  conv55_window_gen dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .win_flat(win_flat), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix(input int y, input int x, input bit inv);
    logic [7:0] p;
    p = 8'((y*32 + x) & 255);
    return inv ? ~p : p;
  endfunction

  // Window for accept at (y,x): slot r*K+c = pixel (y-4+r, x-4+c).
  function automatic logic [WIN_W-1:0] exp_win(input int y, input int x, input bit inv);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DATA_W +: DATA_W] = pix(y-4+r, x-4+c, inv);
    return w;
  endfunction

  function automatic logic [7:0] slot(input logic [WIN_W-1:0] w, input int k);
    return w[k*DATA_W +: DATA_W];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] p);
    in_valid = 1'b1;
    in_pixel = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_pixel = 8'h5A; out_ready = 1'b0;
    step(); step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (win_flat !== '0) begin fails++; $display("FAIL reset_win_flat: got %h want 0", win_flat); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_ramp_first();
    int early;
    early = 0;
    do_reset();
    for (int n = 0; n < 133; n++) begin
      feed(pix(n/32, n%32, 1'b0));
      if (n < 132 && out_valid) early++;
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL ramp_early_valid: got %0d windows want 0", early); end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ramp_first_valid: got %b want 1", out_valid); end
    tests++; if (slot(win_flat,0) !== 8'd0) begin fails++; $display("FAIL ramp_slot0: got %0d want 0", slot(win_flat,0)); end
    tests++; if (slot(win_flat,4) !== 8'd4) begin fails++; $display("FAIL ramp_slot4: got %0d want 4", slot(win_flat,4)); end
    tests++; if (slot(win_flat,20) !== 8'd128) begin fails++; $display("FAIL ramp_slot20: got %0d want 128", slot(win_flat,20)); end
    tests++; if (slot(win_flat,24) !== 8'd132) begin fails++; $display("FAIL ramp_slot24: got %0d want 132", slot(win_flat,24)); end
  endtask

  // Streams nfr ramp frames (frame f inverted when f is odd) and checks every window.
  task automatic run_frames(input int nfr, input string tag);
    int nwin, nfd, bad, vbad;
    bit fd_last;
    nwin = 0; nfd = 0; bad = 0; vbad = 0; fd_last = 0;
    do_reset();
    for (int f = 0; f < nfr; f++)
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) begin
          feed(pix(y, x, f[0]));
          if (out_valid !== ((y >= 4) && (x >= 4))) vbad++;
          if (out_valid) begin
            nwin++;
            if (win_flat !== exp_win(y, x, f[0])) bad++;
          end
          if (frame_done) begin
            nfd++;
            if (y != 31 || x != 31 || !out_valid) vbad++;
          end
          if (f == nfr-1 && y == 31 && x == 31) fd_last = frame_done;
        end
    tests++; if (nwin !== nfr*784) begin fails++; $display("FAIL %s_win_count: got %0d want %0d", tag, nwin, nfr*784); end
    tests++; if (nfd !== nfr) begin fails++; $display("FAIL %s_frame_done_count: got %0d want %0d", tag, nfd, nfr); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL %s_window_data: got %0d bad windows want 0", tag, bad); end
    tests++; if (vbad !== 0) begin fails++; $display("FAIL %s_valid_timing: got %0d bad cycles want 0", tag, vbad); end
    tests++; if (fd_last !== 1'b1) begin fails++; $display("FAIL %s_frame_done_last: got %b want 1", tag, fd_last); end
    if (nfr == 1) begin
      tests++; if (slot(win_flat,24) !== 8'hFF) begin fails++; $display("FAIL %s_last_slot24: got %h want ff", tag, slot(win_flat,24)); end
    end
    step();
    tests++; if (out_valid !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL %s_idle_after: got valid=%b done=%b want 0 0", tag, out_valid, frame_done); end
  endtask

  task automatic test_full_frame();
    run_frames(1, "full");
  endtask

  task automatic test_back_to_back();
    run_frames(2, "b2b");
  endtask

  task automatic test_backpressure();
    logic [WIN_W-1:0] held;
    int rdy_bad, hold_bad;
    rdy_bad = 0; hold_bad = 0;
    do_reset();
    for (int n = 0; n < 133; n++) feed(pix(n/32, n%32, 1'b0));
    held = win_flat;
    out_ready = 1'b0; in_valid = 1'b1; in_pixel = pix(4, 5, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0) rdy_bad++;
      step();
      if (win_flat !== held || out_valid !== 1'b1) hold_bad++;
    end
    tests++; if (rdy_bad !== 0) begin fails++; $display("FAIL bp_in_ready: got %0d ready cycles want 0", rdy_bad); end
    tests++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d changed cycles want 0", hold_bad); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    tests++; if (win_flat !== exp_win(4, 5, 1'b0)) begin fails++; $display("FAIL bp_release_win: got %h want %h", win_flat, exp_win(4, 5, 1'b0)); end
    feed(pix(4, 6, 1'b0));
    tests++; if (out_valid !== 1'b1 || slot(win_flat,24) !== 8'd134) begin fails++; $display("FAIL bp_next_win: got valid=%b slot24=%0d want 1 134", out_valid, slot(win_flat,24)); end
  endtask

  task automatic test_bubbles();
    int nwin, bad, vbad;
    nwin = 0; bad = 0; vbad = 0;
    do_reset();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        while ($urandom_range(1) == 0) begin
          step();
          if (out_valid !== 1'b0) vbad++;
        end
        feed(pix(y, x, 1'b0));
        if (out_valid !== ((y >= 4) && (x >= 4))) vbad++;
        if (out_valid) begin
          nwin++;
          if (win_flat !== exp_win(y, x, 1'b0)) bad++;
        end
      end
    tests++; if (nwin !== 784) begin fails++; $display("FAIL bub_win_count: got %0d want 784", nwin); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL bub_window_data: got %0d bad windows want 0", bad); end
    tests++; if (vbad !== 0) begin fails++; $display("FAIL bub_valid_gating: got %0d bad cycles want 0", vbad); end
  endtask

  task automatic test_reset_mid();
    int early;
    early = 0;
    do_reset();
    for (int n = 0; n < 500; n++) feed(pix(n/32, n%32, 1'b1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    for (int n = 0; n < 133; n++) begin
      feed(pix(n/32, n%32, 1'b0));
      if (n < 132 && out_valid) early++;
    end
    tests++; if (early !== 0) begin fails++; $display("FAIL mid_early_valid: got %0d want 0", early); end
    tests++; if (out_valid !== 1'b1 || win_flat !== exp_win(4, 4, 1'b0)) begin fails++; $display("FAIL mid_first_win: got valid=%b win=%h want 1 %h", out_valid, win_flat, exp_win(4, 4, 1'b0)); end
  endtask

  initial begin
    test_reset();
    test_ramp_first();
    test_full_frame();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
